// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, frame layout and frame check for the PS/2 receiver
package ps2_pkg;

  localparam int         PS2_FRAME_BITS     = 11;
  localparam logic [7:0] PS2_BREAK_CODE     = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE       = 8'hE0;
  localparam int         PS2_FIFO_DEPTH_DEF = 8;
  localparam int         PS2_TIMEOUT_DEF    = 50000;
  localparam logic [3:0] PS2_LAST_BIT       = 4'(PS2_FRAME_BITS - 1);

  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic ps2_frame_ok(input ps2_frame_t f);
    return (f.start == 1'b0) && (f.stop == 1'b1) && (^{f.data, f.parity} == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - byte FIFO with wrap-bit pointers; head reads as 8'h00 when empty
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = PS2_FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [DEPTH];

  logic w_wr;
  logic w_rd;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign w_wr  = push && (!full || pop);
  assign w_rd  = pop && !empty;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rdata = empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with edge detect, frame timeout and byte FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = PS2_FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT_CYC);

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_clk_hist;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_overflow;

  logic          w_fall;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  ps2_frame_t    w_frame;

  assign w_fall  = r_clk_hist && !r_clk_s2;
  // Bit 10 is still on the synchronized data line; bits 0..9 sit in the shift register
  assign w_frame = {r_dat_s2, r_shift};
  assign w_push  = w_fall && (r_bit_cnt == PS2_LAST_BIT) && ps2_frame_ok(w_frame);
  assign w_pop   = !nextdata_n && !w_empty;

  assign ready    = !w_empty;
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      if (r_bit_cnt == PS2_LAST_BIT) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= {r_dat_s2, r_shift[9:1]};
      end
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else if (r_bit_cnt != '0) begin
      r_bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_pop) begin
      r_overflow <= 1'b0;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_frame.data),
    .rdata (data),
    .empty (w_empty),
    .full  (w_full)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized and directed bench for ps2_rx_fifo against a queue model
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit rand_pop = 1'b0;
  int pop_pct  = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         ev_cyc[$];
  logic [7:0] ev_byte[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int fault);
    logic par;
    logic st;
    logic sp;
    par = ~^b;
    st  = 1'b0;
    sp  = 1'b1;
    if (fault == 1) par = ~par;
    if (fault == 2) st = 1'b1;
    if (fault == 3) sp = 1'b0;
    return {sp, par, b, st};
  endfunction

  function automatic bit frame_valid(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

  // Reference model: a byte is committed 3 clk edges after the bench drops ps2_clk
  // (two synchronizer stages plus the edge-detect cycle)
  always @(posedge clk) begin
    logic       pu;
    logic       po;
    logic [7:0] b;
    cyc++;
    b = 8'h00;
    if (!clrn) begin
      mq.delete();
      m_ovf = 1'b0;
      ev_cyc.delete();
      ev_byte.delete();
    end else begin
      po = !nextdata_n && (mq.size() != 0);
      pu = 1'b0;
      if (ev_cyc.size() != 0 && ev_cyc[0] == cyc) begin
        pu = 1'b1;
        b  = ev_byte.pop_front();
        void'(ev_cyc.pop_front());
      end
      if (pu && mq.size() == DEPTH && !po) begin
        m_ovf = 1'b1;
      end else begin
        if (po) begin
          void'(mq.pop_front());
          m_ovf = 1'b0;
        end
        if (pu) mq.push_back(b);
      end
    end
    #1;
    check("ready", {7'b0, ready}, {7'b0, (mq.size() != 0)});
    check("data", data, (mq.size() != 0) ? mq[0] : 8'h00);
    check("overflow", {7'b0, overflow}, {7'b0, m_ovf});
  end

  always @(negedge clk) begin
    if (rand_pop) nextdata_n = ($urandom_range(0, 99) >= pop_pct);
  end

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_commit);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF - 1) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && frame_valid(bits)) begin
        ev_cyc.push_back(cyc + 3);
        ev_byte.push_back(bits[8:1]);
      end
      for (int j = 1; j <= HALF; j++) begin
        @(negedge clk);
        if (pop_commit && i == 10) begin
          if (j == 2) nextdata_n = 1'b0;
          if (j == 3) nextdata_n = 1'b1;
        end
      end
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int fault);
    send_bits(mk_frame(b, fault), 11, 1'b0);
  endtask

  task automatic pop_once();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fault;
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {7'b0, ready}, 8'h00);
    check("rst_data", data, 8'h00);
    check("rst_ovf", {7'b0, overflow}, 8'h00);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    send_byte(8'h1C, 0);
    check("single_ready", {7'b0, ready}, 8'h01);
    check("single_data", data, 8'h1C);
    pop_once();
    check("single_pop_ready", {7'b0, ready}, 8'h00);
    check("single_pop_data", data, 8'h00);

    send_byte(8'h1C, 0);
    send_byte(PS2_BREAK_CODE, 0);
    send_byte(8'h1C, 0);
    check("three_0", data, 8'h1C);
    pop_once();
    check("three_1", data, 8'hF0);
    pop_once();
    check("three_2", data, 8'h1C);
    pop_once();
    check("three_empty", data, 8'h00);
    pop_once();
    check("fourth_pop_ready", {7'b0, ready}, 8'h00);

    send_byte(8'h32, 1);
    send_byte(8'h32, 3);
    check("bad_frames_ready", {7'b0, ready}, 8'h00);
    send_byte(8'h21, 0);
    check("after_bad_data", data, 8'h21);
    pop_once();

    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 0);
    check("ovf_set", {7'b0, overflow}, 8'h01);
    check("ovf_head", data, 8'h10);
    for (int k = 1; k <= 8; k++) begin
      pop_once();
      if (k == 1) check("ovf_clear", {7'b0, overflow}, 8'h00);
      check("ovf_drain", data, (k < 8) ? 8'h10 + 8'(k) : 8'h00);
    end

    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 0);
    send_bits(mk_frame(8'h5A, 0), 11, 1'b1);
    check("fullpop_ovf", {7'b0, overflow}, 8'h00);
    check("fullpop_head", data, 8'h41);
    for (int k = 1; k <= 8; k++) begin
      pop_once();
      check("fullpop_drain", data, (k < 7) ? 8'h41 + 8'(k) : ((k == 7) ? 8'h5A : 8'h00));
    end

    send_bits(mk_frame(8'h77, 0), 5, 1'b0);
    repeat (TO + 1) @(negedge clk);
    send_byte(8'h45, 0);
    check("timeout_data", data, 8'h45);
    pop_once();
    check("timeout_empty", {7'b0, ready}, 8'h00);

    send_bits(mk_frame(8'h77, 0), 5, 1'b0);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h45, 0);
    check("midrst_data", data, 8'h45);
    pop_once();

    rand_pop = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    pop_pct = 0;
        2:       pop_pct = 3;
        3:       pop_pct = 15;
        default: pop_pct = 60;
      endcase
      fault = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      if (fault == 4) begin
        send_bits(mk_frame(8'($urandom), 0), int'($urandom_range(1, 10)), 1'b0);
        repeat (TO + 1) @(negedge clk);
      end else begin
        send_byte(8'($urandom), fault);
      end
    end
    rand_pop = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8; number of received bytes buffered (power of 2, 2..64).
REQ-002 Parameter TIMEOUT_CYC, default 50000; clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 clrn  in  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  in  1  raw PS/2 clock from the device, asynchronous to clk.
REQ-006 ps2_data  in  1  raw PS/2 data from the device, asynchronous to clk.
REQ-007 nextdata_n  in  1  active-low pop request from the consumer; sampled on the clk rising edge.
REQ-008 data  out  8  byte at the FIFO head.
REQ-009 ready  out  1  high while the FIFO is non-empty.
REQ-010 overflow  out  1  sticky flag: a valid frame was dropped because the FIFO was full.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer, plus one history flop on ps2_clk for edge detection.
REQ-012 A falling edge SHALL be detected when the history flop is 1 and the synchronized ps2_clk is 0; ps2_data SHALL be sampled in that same cycle.
REQ-013 Frame: 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1); a 4-bit counter runs 0..10 and wraps to 0 after bit 10.
REQ-014 On the sample of bit 10 the frame SHALL be valid only if start=0, stop=1, and XOR of data and parity = 1; invalid frames are discarded silently, and the counter is still cleared.
REQ-015 A valid frame SHALL be pushed in the cycle bit 10 is sampled; ready and data SHALL reflect it on the next clk edge (1-cycle latency).
REQ-016 Pop SHALL occur when nextdata_n=0 and ready=1; the read pointer advances and data shows the next entry on the following edge.
REQ-017 Pop with the FIFO empty SHALL be ignored, with no pointer change.
REQ-018 Push with the FIFO full and no pop in the same cycle: the byte is dropped, overflow set to 1, and FIFO contents unchanged.
REQ-019 Push and pop in the same cycle SHALL both take effect, including when full: no overflow, and occupancy unchanged.
REQ-020 overflow SHALL clear on the first successful pop after it was set.
REQ-021 data SHALL be 8'h00 whenever ready=0.
REQ-022 Timeout counter: reset on each falling edge and saturating at TIMEOUT_CYC; reaching TIMEOUT_CYC with the bit counter non-zero SHALL clear the bit counter, and the partial frame is lost.
REQ-023 Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.

Reset
REQ-024 clrn=0 SHALL asynchronously clear the synchronizers to idle (ps2_clk/ps2_data flops to 1), bit counter, shift register, timeout counter, pointers and overflow.
REQ-025 During and after reset: ready=0, data=8'h00, overflow=0; FIFO memory contents need not be cleared.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL be received normally if it starts after release.

Structure
REQ-027 Package ps2_pkg SHALL hold PS2_FRAME_BITS=11, PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0, and the default FIFO_DEPTH/TIMEOUT_CYC.
REQ-028 The FIFO SHALL be a separate sub-module ps2_fifo (push, pop, wdata, rdata, empty, full) with the same clk/clrn.
REQ-029 Frame receiver, edge detect and timeout SHALL live in ps2_rx_fifo itself.

Verification
REQ-030 Single frame 8'h1C, good parity -> ready=1 exactly 1 cycle after bit 10 is sampled, data=8'h1C; pulse nextdata_n low 1 cycle -> ready=0, data=8'h00.
REQ-031 Frames 8'h1C, 8'hF0, 8'h1C with no pops -> three entries read back in order 1C, F0, 1C; the fourth pop is ignored.
REQ-032 Frame 8'h32 with wrong parity, then 8'h32 with a bad stop bit -> ready stays 0; next good frame 8'h21 -> data=8'h21.
REQ-033 Nine good frames with no pops (depth 8) -> overflow=1, first 8 bytes intact; one pop -> overflow=0; ninth byte never appears.
REQ-034 FIFO full, pop coincides with bit-10 sample of a good frame -> no overflow, occupancy stays 8, new byte is the last one read.
REQ-035 5 bits sent, TIMEOUT_CYC+1 idle cycles, then full frame 8'h45 -> data=8'h45 with no corruption; repeat with clrn pulsed low mid-frame -> same result.
